// File: rtl/load_reg_arb_pkg.sv
// Shared definitions for the load-register arbiter.
//   state_t    : arbiter FSM encodings (IDLE / LOAD / ACK; 2'd3 is unused)
//   WIDTH_DEF  : default data width of the shared register
//   N_REQ_DEF  : default number of requesters
package load_reg_arb_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans req starting one position after ptr (ptr+1, ptr+2, ... modulo N_REQ)
// and returns the first set index.
//   req     : request vector, bit i belongs to requester i
//   ptr     : index of the most recently served requester
//   winner  : first requesting index after ptr (0 when any_req is low)
//   any_req : high when at least one request bit is set
module rr_pick
  import load_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   winner,
  output logic             any_req
);

  // One extra bit so ptr + offset (at most 2*N_REQ-1) never overflows.
  localparam logic [IDW:0] NR = (IDW+1)'(N_REQ);

  logic [IDW:0] idx;

  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int off = N_REQ; off >= 1; off--) begin
      idx = {1'b0, ptr} + (IDW+1)'(off);
      if (idx >= NR) idx = idx - NR;
      if (req[idx[IDW-1:0]]) winner = idx[IDW-1:0];
    end
  end

endmodule

// File: rtl/load_reg_arbiter.sv
// Round-robin arbiter sharing one downstream load register among N_REQ
// requesters using a four-phase req/ack handshake. One write at a time:
// IDLE -> LOAD (one-cycle load strobe) -> ACK (held until req drops) -> IDLE.
// Outputs decode only from the registered state and grant, so there is no
// combinational path from req to any output.
//
// Optional feature: define LOAD_REG_ARB_STATS_EN to add a saturating write
// counter (write_count) with a synchronous clear input (stats_clr).
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   req         : per-requester write request
//   din         : packed data, requester i at [i*WIDTH +: WIDTH]
//   ack         : per-requester acknowledge (one-hot or zero)
//   reg_load    : load strobe to the shared register
//   reg_d       : data to the shared register (held outside LOAD)
//   grant_id    : index of the current or last granted requester
//   busy        : high whenever the arbiter is not idle
//   stats_clr   : (stats build) synchronous clear of write_count
//   write_count : (stats build) saturating count of LOAD cycles
module load_reg_arbiter
  import load_reg_arb_pkg::*;
#(
  parameter int   WIDTH = WIDTH_DEF,
  parameter int   N_REQ = N_REQ_DEF,
  localparam int  IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
`ifdef LOAD_REG_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [15:0]            write_count,
`endif
  output logic [N_REQ-1:0]       ack,
  output logic                   reg_load,
  output logic [WIDTH-1:0]       reg_d,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] winner;
  logic           any_req;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_ACK;
      // A req dropped already during LOAD leaves ACK after a single cycle.
      ST_ACK:  if (!req[grant_id]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant, pointer and data registers. The data word is captured at
  // the grant edge, so reg_d is valid throughout LOAD and holds afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IDW'(N_REQ-1);
      grant_id <= '0;
      reg_d    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && any_req) begin
        grant_id <= winner;
        reg_d    <= din[winner*WIDTH +: WIDTH];
      end
      if (state_q == ST_LOAD) ptr_q <= grant_id;
    end
  end

  // Moore output decode.
  always_comb begin
    ack      = '0;
    reg_load = (state_q == ST_LOAD);
    busy     = (state_q != ST_IDLE);
    if (state_q == ST_ACK) ack[grant_id] = 1'b1;
  end

`ifdef LOAD_REG_ARB_STATS_EN
  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count <= '0;
    end else if (stats_clr) begin
      write_count <= '0;
    end else if (state_q == ST_LOAD && write_count != 16'hFFFF) begin
      write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_reg_arbiter.sv
// Self-checking bench for load_reg_arbiter (default build; stats checks are
// added when LOAD_REG_ARB_STATS_EN is defined).
module tb_load_reg_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   din = '0;
  logic [N-1:0]     ack;
  logic             reg_load;
  logic [W-1:0]     reg_d;
  logic [IDW-1:0]   grant_id;
  logic             busy;
`ifdef LOAD_REG_ARB_STATS_EN
  logic             stats_clr = 1'b0;
  logic [15:0]      write_count;
`endif

  always #5 clk = ~clk;

  load_reg_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .din         (din),
`ifdef LOAD_REG_ARB_STATS_EN
    .stats_clr   (stats_clr),
    .write_count (write_count),
`endif
    .ack         (ack),
    .reg_load    (reg_load),
    .reg_d       (reg_d),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: who owns the register (-1 none), whether this is the
  // write cycle, and the last-served requester for the rotation.
  int          m_owner = -1;
  bit          m_load  = 1'b0;
  int          m_ptr   = N-1;
  int          m_gid   = 0;
  logic [W-1:0] m_data = '0;
  int          m_count = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_load = 1'b0; m_ptr = N-1; m_gid = 0; m_data = '0; m_count = 0;
    end else begin
`ifdef LOAD_REG_ARB_STATS_EN
      if (stats_clr) m_count = 0;
      else if (m_load && m_count < 65535) m_count++;
`endif
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        if (m_owner >= 0) begin
          m_load = 1'b1;
          m_gid  = m_owner;
          m_data = din[m_owner*W +: W];
        end
      end else if (m_load) begin
        m_load = 1'b0;
        m_ptr  = m_owner;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] e_ack;
      e_ack = '0;
      if (m_owner >= 0 && !m_load) e_ack[m_owner] = 1'b1;
      check("busy", {31'd0, busy}, {31'd0, m_owner >= 0});
      check("ack", {28'd0, ack}, {28'd0, e_ack});
      check("reg_load", {31'd0, reg_load}, {31'd0, m_load});
      check("grant_id", {30'd0, grant_id}, m_gid);
      check("reg_d", {16'd0, reg_d}, {16'd0, m_data});
`ifdef LOAD_REG_ARB_STATS_EN
      check("write_count", {16'd0, write_count}, m_count);
`endif
      if (reg_load) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra_load: got write %0h expected no write", reg_d);
        end else begin
          check("sb_data", {16'd0, reg_d}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int i);
    int t;
    t = 0;
    while (!ack[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("wait_ack", {31'd0, ack[i]}, 32'd1);
  endtask

  task automatic xfer(input int i, input logic [W-1:0] data);
    din[i*W +: W] = data;
    exp_q.push_back(data);
    req[i] = 1'b1;
    wait_ack(i);
    req[i] = 1'b0;
    cyc(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int g[5];
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};

    // Reset state.
    cyc(2);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_load", {31'd0, reg_load}, 32'd0);
    check("rst_reg_d", {16'd0, reg_d}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);
    #2 rst = 1'b0;

    // 1: single request, latency 1 cycle to LOAD, ack the cycle after.
    @(negedge clk);
    din[0 +: W] = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    req = 4'b0001;
    @(negedge clk);
    check("t1_load", {31'd0, reg_load}, 32'd1);
    check("t1_data", {16'd0, reg_d}, 32'h0000BEEF);
    @(negedge clk);
    check("t1_ack", {28'd0, ack}, 32'b0001);
    cyc(3);
    check("t1_ack_hold", {28'd0, ack}, 32'b0001);
    req = '0;
    @(negedge clk);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: all requesting, each drops one cycle after its ack and re-raises.
    pulse_reset();
    for (int i = 0; i < N; i++) din[i*W +: W] = 16'h1000 + 16'(i);
    exp_q.push_back(16'h1000); exp_q.push_back(16'h1001);
    exp_q.push_back(16'h1002); exp_q.push_back(16'h1003);
    exp_q.push_back(16'h1000);
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      @(negedge clk);
      if (reg_load) begin
        g[n] = int'(grant_id);
        n++;
      end
      for (int i = 0; i < N; i++) req[i] = !ack[i];
    end
    req = '0;
    check("t2_loads", n, 32'd5);
    for (int i = 0; i < 5; i++) check("t2_order", g[i], exp_g[i]);
    cyc(3);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // 3: held-high requester keeps ack, no further loads.
    din[2*W +: W] = 16'h2222;
    exp_q.push_back(16'h2222);
    req = 4'b0100;
    wait_ack(2);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (reg_load) n++;
    end
    check("t3_no_load", n, 32'd0);
    check("t3_ack", {28'd0, ack}, 32'b0100);
    req = '0;
    @(negedge clk);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // 4: granted req drops during LOAD: write completes, one-cycle ack.
    din[1*W +: W] = 16'h1111;
    exp_q.push_back(16'h1111);
    req = 4'b0010;
    @(negedge clk);
    check("t4_load", {31'd0, reg_load}, 32'd1);
    req = '0;
    @(negedge clk);
    check("t4_ack", {28'd0, ack}, 32'b0010);
    @(negedge clk);
    check("t4_ack_off", {28'd0, ack}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);

    // 5: async reset mid-LOAD and mid-ACK, then pointer restart.
    din[3*W +: W] = 16'h3333;
    exp_q.push_back(16'h3333);
    req = 4'b1000;
    @(negedge clk);
    check("t5_load", {31'd0, reg_load}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_load", {31'd0, reg_load}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    req = '0;
    @(negedge clk);
    #2 rst = 1'b0;

    din[0 +: W] = 16'h0A0A;
    exp_q.push_back(16'h0A0A);
    req = 4'b0001;
    cyc(2);
    check("t5_ack", {28'd0, ack}, 32'b0001);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ack", {28'd0, ack}, 32'd0);
    check("t5_rst_busy2", {31'd0, busy}, 32'd0);
    req = '0;
    @(negedge clk);
    #2 rst = 1'b0;

    din[0 +: W] = 16'h0B0B;
    din[3*W +: W] = 16'h3B3B;
    exp_q.push_back(16'h0B0B);
    exp_q.push_back(16'h3B3B);
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    check("t5_winner", {30'd0, grant_id}, 32'd0);
    check("t5_wdata", {16'd0, reg_d}, 32'h00000B0B);
    wait_ack(0);
    req[0] = 1'b0;
    wait_ack(3);
    req = '0;
    cyc(2);

`ifdef LOAD_REG_ARB_STATS_EN
    // 6: write counter.
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    xfer(0, 16'h5000);
    xfer(1, 16'h5001);
    xfer(2, 16'h5002);
    check("t6_count3", {16'd0, write_count}, 32'd3);
    din[3*W +: W] = 16'h5003;
    exp_q.push_back(16'h5003);
    req = 4'b1000;
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("t6_clr", {16'd0, write_count}, 32'd0);
    req = '0;
    cyc(2);
    force dut.write_count = 16'hFFFF;
    m_count = 65535;
    #1 release dut.write_count;
    xfer(0, 16'h5004);
    check("t6_sat", {16'd0, write_count}, 32'h0000FFFF);
`endif

    cyc(3);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
